// File: rtl/led_btn_pkg.sv
// Shared types and defaults for the push-button / LED controller.
// Holds the LED mode encoding and the per-mode output select.
package led_btn_pkg;

    typedef enum logic [1:0] {
        LED_FOLLOW = 2'b00,
        LED_TOGGLE = 2'b01,
        LED_BLINK  = 2'b10,
        LED_OFF    = 2'b11
    } led_mode_e;

    // 10 ms debounce and 0.25 s blink half-period at 100 MHz
    localparam int DB_CYCLES_DEF  = 1_000_000;
    localparam int BLINK_HALF_DEF = 25_000_000;

    function automatic logic led_sel(
        input led_mode_e m,
        input logic      level,
        input logic      tog,
        input logic      phase
    );
        logic r;
        r = 1'b0;
        unique case (m)
            LED_FOLLOW: r = level;
            LED_TOGGLE: r = tog;
            LED_BLINK:  r = level & phase;
            LED_OFF:    r = 1'b0;
            default:    r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// One button channel: 2-flop synchroniser, polarity fix,
// stability counter and registered press pulse.
module btn_debounce
    import led_btn_pkg::*;
#(
    parameter logic ACTIVE_LOW = 1'b0,
    parameter int   DB_CYCLES  = DB_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_btn_raw,
    output logic o_level,
    output logic o_press
);

    localparam int CW = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_level;
    logic          r_press;
    logic [CW-1:0] r_cnt;
    logic          w_norm;

    assign w_norm  = r_sync2 ^ ACTIVE_LOW;
    assign o_level = r_level;
    assign o_press = r_press;

    // Synchroniser resets to the released pin level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= ACTIVE_LOW;
            r_sync2 <= ACTIVE_LOW;
        end else begin
            r_sync1 <= i_btn_raw;
            r_sync2 <= r_sync1;
        end
    end

    // Accept a new level only after DB_CYCLES stable cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_press <= 1'b0;
        end else begin
            r_press <= 1'b0;
            if (w_norm == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_MAX) begin
                r_level <= w_norm;
                r_press <= w_norm;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/led_btn_ctrl.sv
// Multi-channel button to LED controller: debounced levels,
// press pulses, shared blink timebase and per-channel LED modes.
module led_btn_ctrl
    import led_btn_pkg::*;
#(
    parameter int              N_CH           = 2,
    parameter logic [N_CH-1:0] BTN_ACTIVE_LOW = N_CH'(1),
    parameter int              DB_CYCLES      = DB_CYCLES_DEF,
    parameter int              BLINK_HALF     = BLINK_HALF_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_CH-1:0]   btn_raw,
    input  logic [2*N_CH-1:0] mode,
    output logic [N_CH-1:0]   led,
    output logic [N_CH-1:0]   btn_level,
    output logic [N_CH-1:0]   btn_press
);

    localparam int BW = (BLINK_HALF > 2) ? $clog2(BLINK_HALF) : 1;
    localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_HALF - 1);

    logic [BW-1:0]   r_presc;
    logic            r_phase;
    logic [N_CH-1:0] r_tog;
    logic [N_CH-1:0] r_led;
    logic [N_CH-1:0] w_level;
    logic [N_CH-1:0] w_press;
    logic [N_CH-1:0] w_tog_next;
    logic [N_CH-1:0] w_led_next;

    genvar g;
    generate
        for (g = 0; g < N_CH; g++) begin : g_ch
            btn_debounce #(
                .ACTIVE_LOW (BTN_ACTIVE_LOW[g]),
                .DB_CYCLES  (DB_CYCLES)
            ) u_db (
                .clk       (clk),
                .rst_n     (rst_n),
                .i_btn_raw (btn_raw[g]),
                .o_level   (w_level[g]),
                .o_press   (w_press[g])
            );
        end
    endgenerate

    assign btn_level = w_level;
    assign btn_press = w_press;
    assign led       = r_led;

    // Free-running blink timebase shared by all channels
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc <= '0;
            r_phase <= 1'b0;
        end else if (r_presc == BLINK_MAX) begin
            r_presc <= '0;
            r_phase <= ~r_phase;
        end else begin
            r_presc <= r_presc + BW'(1);
        end
    end

    // Next toggle state and per-channel LED source select
    always_comb begin
        w_tog_next = r_tog ^ w_press;
        w_led_next = '0;
        for (int i = 0; i < N_CH; i++) begin
            w_led_next[i] = led_sel(led_mode_e'(mode[2*i +: 2]),
                                    w_level[i], w_tog_next[i],
                                    r_phase);
        end
    end

    // Toggle bits track presses in every mode; LEDs registered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tog <= '0;
            r_led <= '0;
        end else begin
            r_tog <= w_tog_next;
            r_led <= w_led_next;
        end
    end

endmodule

// File: tb/tb_led_btn_ctrl.sv
// Directed self-checking bench for led_btn_ctrl
// with N_CH=2, BTN_ACTIVE_LOW=2'b01, DB_CYCLES=4, BLINK_HALF=8.
module tb_led_btn_ctrl;

    logic       clk;
    logic       rst_n;
    logic [1:0] btn_raw;
    logic [3:0] mode;
    logic [1:0] led;
    logic [1:0] btn_level;
    logic [1:0] btn_press;

    int n_chk;
    int n_err;

    led_btn_ctrl #(
        .N_CH           (2),
        .BTN_ACTIVE_LOW (2'b01),
        .DB_CYCLES      (4),
        .BLINK_HALF     (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn_raw   (btn_raw),
        .mode      (mode),
        .led       (led),
        .btn_level (btn_level),
        .btn_press (btn_press)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench 1 time unit after a posedge with reset released,
    // so the next posedge is edge 1 of normal operation.
    task automatic do_reset();
        rst_n   = 1'b0;
        btn_raw = 2'b01;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        int exp_led;
        n_chk   = 0;
        n_err   = 0;
        rst_n   = 1'b0;
        btn_raw = 2'b01;
        mode    = 4'b0000;
        #2;
        check("reset_outs", {led, btn_level, btn_press}, 6'b0);
        tick();
        do_reset();

        // Reset while both buttons held
        btn_raw = 2'b10;
        repeat (10) tick();
        check("held_level", btn_level, 2'b11);
        rst_n = 1'b0;
        #1;
        check("async_rst", {led, btn_level, btn_press}, 6'b0);
        btn_raw = 2'b01;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 50; i++) begin
            tick();
            check("idle_50", {led, btn_level, btn_press}, 6'b0);
        end

        // Reset mid-debounce, held button re-accepted with a pulse
        btn_raw = 2'b10;
        repeat (3) tick();
        rst_n = 1'b0;
        #1;
        check("mid_db_rst", {btn_level, btn_press}, 4'b0);
        tick();
        rst_n = 1'b1;
        repeat (5) tick();
        check("reacc_pre", btn_level, 2'b00);
        tick();
        check("reacc_lvl", btn_level, 2'b11);
        check("reacc_prs", btn_press, 2'b11);

        // Clean press/release in FOLLOW mode on ch0
        do_reset();
        mode    = 4'b0000;
        btn_raw = 2'b00;
        repeat (5) tick();
        check("fol_pre5", {btn_level, btn_press}, 4'b0);
        tick();
        check("fol_lvl6", btn_level, 2'b01);
        check("fol_prs6", btn_press, 2'b01);
        check("fol_led6", led, 2'b00);
        tick();
        check("fol_prs7", btn_press, 2'b00);
        check("fol_led7", led, 2'b01);
        btn_raw = 2'b01;
        repeat (5) tick();
        check("rel_lvl5", btn_level, 2'b01);
        tick();
        check("rel_lvl6", btn_level, 2'b00);
        check("rel_prs6", btn_press, 2'b00);
        tick();
        check("rel_led7", led, 2'b00);
        check("rel_prs7", btn_press, 2'b00);

        // Bounce on ch1 (active-high)
        do_reset();
        for (int i = 0; i < 12; i++) begin
            btn_raw[1] = ((i / 2) % 2) == 0;
            tick();
            check("bounce", btn_level, 2'b00);
        end
        btn_raw[1] = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            tick();
            check("bnc_lvl", btn_level[1], (k == 6));
            check("bnc_prs", btn_press[1], (k == 6));
        end
        tick();
        check("bnc_one", btn_press, 2'b00);

        // TOGGLE mode on ch0, three presses
        do_reset();
        mode = 4'b0001;
        for (int p = 0; p < 3; p++) begin
            btn_raw[0] = 1'b0;
            repeat (6) tick();
            check("tog_prs", btn_press[0], 1'b1);
            check("tog_old", led[0], (p % 2) != 0);
            tick();
            check("tog_new", led[0], (p % 2) == 0);
            btn_raw[0] = 1'b1;
            repeat (10) tick();
            check("tog_hold", led[0], (p % 2) == 0);
        end

        // BLINK mode on ch1; edge e counted from reset release
        do_reset();
        mode       = 4'b1011;
        btn_raw[1] = 1'b1;
        for (int e = 1; e <= 56; e++) begin
            tick();
            if (e == 36) btn_raw[1] = 1'b0;
            if (e >= 7) begin
                exp_led = ((e - 1) >= 6 && (e - 1) <= 41)
                        ? (((e - 1) / 8) % 2) : 0;
                check("blink", led[1], exp_led[0]);
            end
        end

        // Simultaneous presses, ch0 OFF / ch1 FOLLOW
        do_reset();
        mode    = 4'b0011;
        btn_raw = 2'b10;
        repeat (6) tick();
        check("sim_prs", btn_press, 2'b11);
        check("sim_lvl", btn_level, 2'b11);
        tick();
        check("sim_led", led, 2'b10);
        check("sim_prs0", btn_press, 2'b00);
        mode = 4'b0001;
        tick();
        check("sim_tog", led, 2'b11);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/led_btn_ctrl.md
Name: led_btn_ctrl

Overview:
Multi-channel push-button to LED controller for the board's user I/O. Each channel performs the following steps:
- synchronises a raw button input
- normalises its polarity
- debounces it
- drives one LED in a run-time selectable mode: follow, toggle, blink-while-held, or off

It sits directly between the board pins and the rest of the PL logic, and exports clean button levels and press pulses for other blocks.

Parameters:
N_CH, 2, number of button/LED channels (1..16)
BTN_ACTIVE_LOW, 2'b01, per-channel mask, bit set = raw button is active-low; width N_CH
DB_CYCLES, 1_000_000, consecutive stable clk cycles needed to accept a level change (10 ms at 100 MHz); must be >= 2
BLINK_HALF, 25_000_000, clk cycles per blink half-period; must be >= 2

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
btn_raw  in  N_CH  raw button pins, asynchronous to clk
mode  in  2*N_CH  per-channel LED mode; bits [2i+1:2i] belong to channel i
led  out  N_CH  LED drive, 1 = lit, registered
btn_level  out  N_CH  debounced, polarity-normalised button level, 1 = pressed
btn_press  out  N_CH  one-cycle pulse on each accepted press (0->1 of btn_level)

Behaviour:
- Reset values (asynchronous on rst_n low):
  - led = 0, btn_level = 0, btn_press = 0.
  - Toggle state = 0.
  - Debounce counters = 0.
  - Blink prescaler = 0, blink phase = 0.
  - Synchroniser flops = BTN_ACTIVE_LOW[i], i.e. the released level.
- Reset deassertion needs no special sequencing; the first edge after release is normal operation.
- Synchroniser: 2-flop per channel on btn_raw. Polarity normalisation happens after the synchroniser: norm = sync2 XOR BTN_ACTIVE_LOW[i].
- Debounce, per channel:
  - Counter cnt, width $clog2(DB_CYCLES).
  - If norm == btn_level: cnt <= 0.
  - Else if cnt == DB_CYCLES-1: btn_level <= norm and cnt <= 0.
  - Else: cnt <= cnt+1.
  - Any bounce back to the accepted level restarts the count.
- Latency: a clean raw edge changes btn_level exactly 2+DB_CYCLES clk edges later.
- btn_press: registered so it is high in the same cycle btn_level first reads 1. Release generates no pulse.
- Blink:
  - One shared prescaler counts 0..BLINK_HALF-1. At terminal count it wraps to 0 and toggles the blink phase.
  - Free-running, never reset by button activity.
- LED modes, per channel (led registered, 1 cycle after its source):
  - 2'b00 FOLLOW: led <= btn_level.
  - 2'b01 TOGGLE: the toggle bit flips on btn_press; led <= toggle bit.
  - 2'b10 BLINK: led <= btn_level AND blink phase.
  - 2'b11 OFF: led <= 0.
- Toggle bit:
  - Updates on btn_press in every mode, so switching into TOGGLE shows the current state.
  - It is cleared only by reset.
- Mode changes take effect on the next clk edge; there is no glitch filtering on mode.
- Channels are fully independent. Simultaneous presses on several channels each produce their own pulse in the same cycle.
- Reset mid-debounce: counter cleared and no press generated. After release, a held button is re-accepted after 2+DB_CYCLES cycles, and this produces a btn_press pulse.
- Counter widths must hold DB_CYCLES-1 and BLINK_HALF-1 without overflow. There is no wrap-around other than the specified terminal counts.

Decomposition:
- Package led_btn_pkg holds:
  - typedef enum logic [1:0] led_mode_e {LED_FOLLOW, LED_TOGGLE, LED_BLINK, LED_OFF}
  - localparam defaults for DB_CYCLES and BLINK_HALF at 100 MHz.
- Sub-module btn_debounce (one channel) contains:
  - the synchroniser, polarity XOR, debounce counter and press-edge register
  - parameters ACTIVE_LOW and DB_CYCLES.
- led_btn_ctrl contains:
  - a generate loop of N_CH btn_debounce instances
  - the shared blink prescaler
  - the per-channel mode mux and toggle bit.

Test Plan:
All scenarios use N_CH=2, BTN_ACTIVE_LOW=2'b01, DB_CYCLES=4, BLINK_HALF=8.
- Reset: assert rst_n=0 mid-run with buttons held -> led, btn_level, btn_press all 0 immediately. Release with btn_raw=2'b01 (both idle) -> all outputs stay 0 for 50 cycles.
- Clean press, FOLLOW mode: ch0 btn_raw 1->0 -> btn_level[0]=1 and a single-cycle btn_press[0] exactly 6 edges later, led[0]=1 one edge after that. Release -> btn_level[0]=0 six edges later, no pulse.
- Bounce: ch1 raw toggles 0/1/0 every 2 cycles for 12 cycles then holds 1 -> no btn_level change during the bounce, one press accepted 6 cycles after the final edge.
- TOGGLE mode ch0: three separate clean presses -> led[0] sequence 1,0,1, each change one cycle after the corresponding btn_press.
- BLINK mode ch1: held button -> led[1] toggles every 8 cycles while held, 0 after release is accepted.
- Simultaneous: both channels pressed on the same edge, with ch0=OFF and ch1=FOLLOW -> both btn_press pulse in the same cycle, led=2'b10. Switching ch0 to TOGGLE then shows led[0]=1 from the pre-recorded toggle.
